// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-256 decryptor.
// S-box values are computed from the field inverse and affine map rather than tabulated.
package aes_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_KEXP = 2'd1,
    S_DEC  = 2'd2,
    S_DONE = 2'd3
  } aes_state_e;

  localparam int AES_NR = 14;
  localparam int AES_NK = 8;

  // Entry i holds Rcon[i]; entry 0 is unused.
  localparam logic [7:0][7:0] RCON_TAB = {8'h40, 8'h20, 8'h10, 8'h08,
                                          8'h04, 8'h02, 8'h01, 8'h00};

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x;
    logic [7:0] r;
    x = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      x = gf_mul(x, x);
      r = gf_mul(r, x);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  // Byte k of the block sits at bits [127-8k -: 8]; row r, column c is byte 4c+r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box, combinational, one byte; sixteen of these form InvSubBytes.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = sbox_inv(a);

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, combinational, one byte; used by the key expansion.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = sbox_fwd(a);

endmodule

// File: rtl/aes_256_dec_iter.sv
// Iterative AES-256 decryptor: expands the key in 13 cycles, then one inverse round per cycle.
// Optional AES_KEY_CACHE_EN: skip key expansion when the key repeats the last expanded one.
module aes_256_dec_iter
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [127:0]            state,
  input  logic [32*AES_NK-1:0]    key,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [127:0]            out
);

  aes_state_e   fsm_r, fsm_s;
  logic [3:0]   kcnt_r, rnd_r;
  logic [127:0] blk_r, out_r;
  logic         in_ready_r, out_valid_r;
  logic         acc_s, hit_s;

  logic [127:0] rk_s [0:NR];
  logic [3:0]   kp1_s, kp2_s;
  logic [31:0]  kw_last_s, sub_in_s, sub_out_s, temp_s;
  logic [31:0]  w0_s, w1_s, w2_s, w3_s;
  logic [127:0] prev2_s, rk_new_s;
  logic [127:0] rnd_in_s, isr_s, isb_s, ark_s, rnd_out_s;

  assign acc_s     = (fsm_r == S_IDLE) && in_valid;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out       = out_r;

`ifdef AES_KEY_CACHE_EN
  logic [32*AES_NK-1:0] kc_r;
  logic                 key_ok_r;

  // Cached key tag; valid only once its expansion has fully landed in the key file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kc_r     <= 256'h0;
      key_ok_r <= 1'b0;
    end else if (acc_s && !hit_s) begin
      kc_r     <= key;
      key_ok_r <= 1'b0;
    end else if ((fsm_r == S_KEXP) && (kcnt_r == 4'(NR))) begin
      key_ok_r <= 1'b1;
    end
  end

  assign hit_s = key_ok_r && (key == kc_r);
`else
  assign hit_s = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    fsm_s = fsm_r;
    case (fsm_r)
      S_IDLE: begin
        if (in_valid) fsm_s = hit_s ? S_DEC : S_KEXP;
        else          fsm_s = S_IDLE;
      end
      S_KEXP: begin
        if (kcnt_r == 4'(NR)) fsm_s = S_DEC;
        else                  fsm_s = S_KEXP;
      end
      S_DEC: begin
        if (rnd_r == 4'd0) fsm_s = S_DONE;
        else               fsm_s = S_DEC;
      end
      S_DONE: begin
        if (out_ready) fsm_s = S_IDLE;
        else           fsm_s = S_DONE;
      end
      default: fsm_s = S_IDLE;
    endcase
  end

  // State register, counters, block register and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r       <= S_IDLE;
      kcnt_r      <= 4'd0;
      rnd_r       <= 4'd0;
      blk_r       <= 128'h0;
      out_r       <= 128'h0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      fsm_r       <= fsm_s;
      in_ready_r  <= (fsm_s == S_IDLE);
      out_valid_r <= (fsm_s == S_DONE);
      case (fsm_r)
        S_IDLE: begin
          if (acc_s) begin
            blk_r  <= state;
            kcnt_r <= hit_s ? 4'd0 : 4'd2;
            rnd_r  <= 4'(NR - 1);
          end
        end
        S_KEXP: begin
          kcnt_r <= (kcnt_r == 4'(NR)) ? 4'd0 : kcnt_r + 4'd1;
        end
        S_DEC: begin
          blk_r <= rnd_out_s;
          if (rnd_r == 4'd0) out_r <= rnd_out_s;
          else               rnd_r <= rnd_r - 4'd1;
        end
        S_DONE: begin
          blk_r <= blk_r;
        end
        default: begin
          kcnt_r <= 4'd0;
          rnd_r  <= 4'd0;
        end
      endcase
    end
  end

  // Round-key file: entries 0/1 take the raw key halves, the rest one per KEXP cycle
  for (genvar g = 0; g <= NR; g++) begin : g_rk
    logic [127:0] q_r;
    // One round-key entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                         q_r <= 128'h0;
      else if (acc_s && (g == 0))                         q_r <= key[255:128];
      else if (acc_s && (g == 1))                         q_r <= key[127:0];
      else if ((fsm_r == S_KEXP) && (kcnt_r == 4'(g)))    q_r <= rk_new_s;
    end
    assign rk_s[g] = q_r;
  end

  // Key schedule: pick the words feeding SubWord; indices clamped while idle
  always_comb begin
    if (kcnt_r >= 4'd2) begin
      kp1_s = kcnt_r - 4'd1;
      kp2_s = kcnt_r - 4'd2;
    end else begin
      kp1_s = 4'd1;
      kp2_s = 4'd0;
    end
    kw_last_s = rk_s[kp1_s][31:0];
    if (kcnt_r[0]) sub_in_s = kw_last_s;
    else           sub_in_s = {kw_last_s[23:0], kw_last_s[31:24]};
  end

  for (genvar g = 0; g < 4; g++) begin : g_ksb
    aes_sbox u_sbox (.a(sub_in_s[8*g +: 8]), .y(sub_out_s[8*g +: 8]));
  end

  // Key schedule: Rcon on even steps, then chain the four words
  always_comb begin
    if (kcnt_r[0]) temp_s = sub_out_s;
    else           temp_s = sub_out_s ^ {RCON_TAB[kcnt_r[3:1]], 24'h000000};
    prev2_s  = rk_s[kp2_s];
    w0_s     = prev2_s[127:96] ^ temp_s;
    w1_s     = prev2_s[95:64]  ^ w0_s;
    w2_s     = prev2_s[63:32]  ^ w1_s;
    w3_s     = prev2_s[31:0]   ^ w2_s;
    rk_new_s = {w0_s, w1_s, w2_s, w3_s};
  end

  // Round input: the first round also folds in the final round key
  always_comb begin
    if (rnd_r == 4'(NR - 1)) rnd_in_s = blk_r ^ rk_s[NR];
    else                     rnd_in_s = blk_r;
    isr_s = inv_shift_rows(rnd_in_s);
  end

  for (genvar g = 0; g < 16; g++) begin : g_isb
    aes_inv_sbox u_inv_sbox (.a(isr_s[8*g +: 8]), .y(isb_s[8*g +: 8]));
  end

  // AddRoundKey, then InvMixColumns on every round except the last
  always_comb begin
    ark_s = isb_s ^ rk_s[rnd_r];
    if (rnd_r == 4'd0) rnd_out_s = ark_s;
    else               rnd_out_s = inv_mix_columns(ark_s);
  end

endmodule
